multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller.sv | 211 +++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V control FSM (lw, sw, R/I ALU ops, beq, jal) with a HALT trap for unsupported encodings.
// Define MEM_WAIT_EN to stall FETCH, MEMREAD and MEMWRITE until mem_ready is high.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    function automatic logic funct_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // sub_ok is only set for R-type, so addi never turns into a subtract.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        logic [2:0] cmd;
        case (f3)
            3'b000:  cmd = sub_ok ? 3'b001 : 3'b000;
            3'b010:  cmd = 3'b101;
            3'b110:  cmd = 3'b011;
            3'b111:  cmd = 3'b010;
            default: cmd = 3'b000;
        endcase
        return cmd;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [6:0] opc,
                                          input logic [2:0] f3, input logic f7b5);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (opc == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = alu_decode(f3, f7b5);
            end
            S_EXECI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.alu_control = alu_decode(f3, 1'b0);
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = 3'b001;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_HALT:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mem_ok_s;
    logic   gate_s;

`ifdef MEM_WAIT_EN
    assign mem_ok_s = mem_ready;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = mem_ready;
    assign mem_ok_s           = 1'b1;
`endif

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ok_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ok_s ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ok_s ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI: begin
                if (funct_legal(funct3)) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    // State register; control word is precomputed for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH, 7'd0, 3'd0, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, op, funct3, funct7b5);
        end
    end

    // Write strobes that wait on memory fire only in the cycle the access completes.
    assign gate_s = ((state_q == S_FETCH) || (state_q == S_MEMWRITE)) ? mem_ok_s : 1'b1;

    // rst masks everything so a write in flight is cut off the instant reset rises.
    assign pc_write    = !rst && ((ctrl_q.pc_write && gate_s) || ((state_q == S_BEQ) && zero));
    assign ir_write    = !rst && ctrl_q.ir_write  && gate_s;
    assign mem_write   = !rst && ctrl_q.mem_write && gate_s;
    assign reg_write   = !rst && ctrl_q.reg_write;
    assign adr_src     = !rst && ctrl_q.adr_src;
    assign illegal     = !rst && ctrl_q.illegal;
    assign alu_src_a   = rst ? 2'b00  : ctrl_q.alu_src_a;
    assign alu_src_b   = rst ? 2'b00  : ctrl_q.alu_src_b;
    assign result_src  = rst ? 2'b00  : ctrl_q.result_src;
    assign imm_src     = rst ? 2'b00  : ctrl_q.imm_src;
    assign alu_control = rst ? 3'b000 : ctrl_q.alu_control;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized self-checking bench for multi_cycle_controller: an instruction-level model
// expands each instruction into its expected per-cycle control words.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;

    int checks = 0;
    int errors = 0;

    multi_cycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
                      result_src, imm_src, alu_control, illegal};

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_WB, P_B, P_J, P_H} phase_t;

    phase_t      seq_q[$];
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];

    function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic mw,
                                       input logic rw, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill);
        return {pcw, irw, mw, rw, adr, a, b, res, imm, alu, ill};
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [16:0] expected_vec(input phase_t ph, input logic [6:0] opc,
                                                 input logic [2:0] f3, input logic f7,
                                                 input logic z);
        case (ph)
            P_F:   return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0);
            P_D:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 1'b0);
            P_MA:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00,
                             (opc == 7'b0100011) ? 2'b01 : 2'b00, 3'b000, 1'b0);
            P_MR:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
            P_MWB: return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0);
            P_MW:  return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
            P_ER:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00,
                             alu_of(f3, f7, 1'b1), 1'b0);
            P_EI:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00,
                             alu_of(f3, f7, 1'b0), 1'b0);
            P_WB:  return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
            P_B:   return mk(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0);
            P_J:   return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0);
            P_H:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
            default: return 17'h1FFFF;
        endcase
    endfunction

    function automatic void build_seq(input logic [6:0] opc, input logic [2:0] f3);
        logic ok;
        ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
        seq_q.delete();
        seq_q.push_back(P_F);
        seq_q.push_back(P_D);
        case (opc)
            7'b0000011: begin seq_q.push_back(P_MA); seq_q.push_back(P_MR); seq_q.push_back(P_MWB); end
            7'b0100011: begin seq_q.push_back(P_MA); seq_q.push_back(P_MW); end
            7'b0110011: begin seq_q.push_back(P_ER); seq_q.push_back(ok ? P_WB : P_H); end
            7'b0010011: begin seq_q.push_back(P_EI); seq_q.push_back(ok ? P_WB : P_H); end
            7'b1100011: seq_q.push_back(P_B);
            7'b1101111: begin seq_q.push_back(P_J); seq_q.push_back(P_WB); end
            default:    seq_q.push_back(P_H);
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle; zmode 0/1 forces zero, 2 randomizes it per cycle.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input int zmode);
        logic zv;
        build_seq(opc, f3);
        obs_q.delete();
        exp_q.delete();
        op = opc;
        funct3 = f3;
        funct7b5 = f7;
        foreach (seq_q[k]) begin
            zv = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            zero = zv;
`ifdef MEM_WAIT_EN
            mem_ready = 1'b1;
`else
            mem_ready = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            obs_q.push_back(dut_vec);
            exp_q.push_back(expected_vec(seq_q[k], opc, f3, f7, zv));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected %h", dut_vec, 17'd0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(7'b0000011, 3'b010, 1'b0, 2);
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL lw_after_reset cycle %0d: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            run_instr(7'b1100011, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), z);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL beq_zero%0d cycle %0d: got %h expected %h", z, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_funct;
        logic [6:0] ops [3];
        logic [2:0] f3s [3];
        ops = '{7'b0110011, 7'b0110011, 7'b0010011};
        f3s = '{3'b000, 3'b010, 3'b000};
        for (int t = 0; t < 3; t++) begin
            run_instr(ops[t], f3s[t], 1'b1, 2);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL funct_%0d cycle %0d: got %h expected %h", t, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [6];
        logic [2:0] f3s [4];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        f3s = '{3'b000, 3'b010, 3'b110, 3'b111};
        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 5)], f3s[$urandom_range(0, 3)],
                      1'($urandom_range(0, 1)), 2);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL random_%0d op %b cycle %0d: got %h expected %h",
                             n, op, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_halt;
        logic [6:0] ops [2];
        logic [2:0] f3s [2];
        logic [16:0] halt_vec;
        ops = '{7'b1111111, 7'b0110011};
        f3s = '{3'b000, 3'b001};
        halt_vec = expected_vec(P_H, 7'd0, 3'd0, 1'b0, 1'b0);
        for (int t = 0; t < 2; t++) begin
            run_instr(ops[t], f3s[t], 1'b0, 2);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL halt_entry_%0d cycle %0d: got %h expected %h", t, k, obs_q[k], exp_q[k]);
                end
            end
            for (int c = 0; c < 20; c++) begin
                op = 7'($urandom);
                funct3 = 3'($urandom);
                zero = 1'($urandom_range(0, 1));
                mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if (dut_vec !== halt_vec) begin
                    errors++;
                    $display("FAIL halt_hold_%0d cycle %0d: got %h expected %h", t, c, dut_vec, halt_vec);
                end
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (dut_vec !== 17'd0) begin
                errors++;
                $display("FAIL halt_reset_%0d: got %h expected %h", t, dut_vec, 17'd0);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
            run_instr(7'b1101111, 3'b000, 1'b0, 2);
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL halt_recover_%0d cycle %0d: got %h expected %h", t, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        op = 7'b0100011;
        funct3 = 3'b010;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_mem_write: got %b expected %b", mem_write, 1'b1);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected %h", dut_vec, 17'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold_mem_write: got %b expected %b", mem_write, 1'b0);
        end
        rst = 1'b0;
        run_instr(7'b0110011, 3'b110, 1'b0, 2);
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL abort_recover cycle %0d: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait;
        phase_t      ph [8];
        logic [16:0] exp_v;
        ph = '{P_F, P_D, P_MA, P_MW, P_MW, P_MW, P_MW, P_F};
        op = 7'b0100011;
        funct3 = 3'b010;
        for (int c = 0; c < 8; c++) begin
            mem_ready = !((c >= 3) && (c <= 5));
            @(negedge clk);
            exp_v = expected_vec(ph[c], op, funct3, 1'b0, 1'b0);
            if (ph[c] == P_MW && c != 6) begin
                exp_v[14] = 1'b0;
            end
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL mem_wait cycle %0d: got %h expected %h", c, dut_vec, exp_v);
            end
            if (c < 7) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_beq;
        test_funct;
        test_random;
        test_halt;
        test_reset_abort;
`ifdef MEM_WAIT_EN
        test_mem_wait;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
